// File: rtl/pipe_ctl_pkg.sv
// Shared types for the pipeline sequencer.
//   pctl_state_t : sequencer FSM states
//   stage_ctl_t  : load-enable / flush pair for one pipeline register
//   pipe_ctl_t   : full set of per-stage controls driven by pipe_ctl
package pipe_ctl_pkg;

    typedef enum logic [1:0] {
        PCTL_INIT,
        PCTL_RUN,
        PCTL_DRAIN,
        PCTL_HALTED
    } pctl_state_t;

    typedef struct packed {
        logic en;
        logic flush;   // for ID/EX this is the bubble insert
    } stage_ctl_t;

    // The PC, EX/MEM and MEM/WB registers are never flushed, so they carry an enable only.
    typedef struct packed {
        logic       pc_en;
        stage_ctl_t ifid;
        stage_ctl_t idex;
        logic       exmem_en;
        logic       memwb_en;
    } pipe_ctl_t;

    // Downstream stages still to be retired after fetching stops.
    localparam int DRAIN_CYCLES = 3;

    // Every register holds its value; nothing is flushed.
    localparam pipe_ctl_t CTL_FREEZE = '0;

    // Normal flow: every register loads.
    localparam pipe_ctl_t CTL_FLOW = '{
        pc_en: 1'b1, ifid: '{en: 1'b1, flush: 1'b0}, idex: '{en: 1'b1, flush: 1'b0},
        exmem_en: 1'b1, memwb_en: 1'b1};

    // Load-use hold: PC and IF/ID keep their values, a bubble enters EX.
    localparam pipe_ctl_t CTL_STALL = '{
        pc_en: 1'b0, ifid: '{en: 1'b0, flush: 1'b0}, idex: '{en: 1'b1, flush: 1'b1},
        exmem_en: 1'b1, memwb_en: 1'b1};

    // PC holds, IF/ID takes a NOP, the rest of the pipe advances.
    localparam pipe_ctl_t CTL_NO_FETCH = '{
        pc_en: 1'b0, ifid: '{en: 1'b1, flush: 1'b1}, idex: '{en: 1'b1, flush: 1'b0},
        exmem_en: 1'b1, memwb_en: 1'b1};

endpackage

// File: rtl/pipe_ctl_perf_cnt.sv
// Free-running event counter that wraps modulo 2^CNT_WIDTH.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the count
//   inc     : add one this cycle
//   clear   : synchronous clear, wins over inc
//   cnt     : current count
module perf_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] cnt
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctl.sv
// Central sequencer for the 5-stage pipeline registers.
// Merges load-use stall, EX jump redirect, memory waits and halt requests into
// per-stage enable/flush/bubble controls, sequences the post-reset flush and the
// halt drain, and counts stall cycles and jump flushes.
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   id_stall             : decode load-use hazard
//   ex_jmp_taken         : jump resolved in EX, two younger instructions are wrong-path
//   imem_wait, dmem_wait : fetch / MEM-stage access not complete
//   halt_req             : level request to stop fetching and drain
//   pc_en, *_en          : register load enables
//   ifid_flush           : load a NOP into IF/ID
//   idex_bubble          : load a bubble into ID/EX
//   halted               : pipeline drained and stopped
//   stall_cnt, flush_cnt : performance counters
module pipe_ctl
    import pipe_ctl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 id_stall,
    input  logic                 ex_jmp_taken,
    input  logic                 imem_wait,
    input  logic                 dmem_wait,
    input  logic                 halt_req,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_en,
    output logic                 idex_bubble,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    // One down-counter serves both the INIT flush and the DRAIN sequence.
    localparam int SEQ_W = ($clog2(INIT_CYCLES) > 2) ? $clog2(INIT_CYCLES) : 2;
    localparam logic [SEQ_W-1:0] INIT_LOAD  = SEQ_W'(INIT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'(DRAIN_CYCLES);

    pctl_state_t      state, state_nxt;
    logic [SEQ_W-1:0] seq_cnt, seq_cnt_nxt;
    pipe_ctl_t        ctl;
    logic             stall_inc;
    logic             flush_inc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= PCTL_INIT;
            seq_cnt <= INIT_LOAD;
        end else begin
            state   <= state_nxt;
            seq_cnt <= seq_cnt_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        seq_cnt_nxt = seq_cnt;
        ctl         = CTL_FREEZE;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state)
            PCTL_INIT: begin
                // Flush every stage register; the PC stays at its reset vector.
                ctl = '{pc_en: 1'b0, ifid: '{en: 1'b1, flush: 1'b1},
                        idex: '{en: 1'b1, flush: 1'b1}, exmem_en: 1'b1, memwb_en: 1'b1};
                if (seq_cnt == '0) begin
                    state_nxt = PCTL_RUN;
                end else begin
                    seq_cnt_nxt = seq_cnt - SEQ_W'(1);
                end
            end

            PCTL_RUN: begin
                // A pending dmem_wait freezes everything, including the halt decision.
                if (!dmem_wait) begin
                    if (ex_jmp_taken) begin
                        // Redirect wins over stall/imem_wait: both concern wrong-path work.
                        ctl = '{pc_en: 1'b1, ifid: '{en: 1'b1, flush: 1'b1},
                                idex: '{en: 1'b1, flush: 1'b1}, exmem_en: 1'b1, memwb_en: 1'b1};
                        flush_inc = 1'b1;
                    end else if (id_stall) begin
                        ctl       = CTL_STALL;
                        stall_inc = 1'b1;
                    end else if (imem_wait) begin
                        ctl = CTL_NO_FETCH;
                    end else begin
                        ctl = CTL_FLOW;
                    end

                    if (halt_req) begin
                        state_nxt   = PCTL_DRAIN;
                        seq_cnt_nxt = DRAIN_LOAD;
                    end
                end
            end

            PCTL_DRAIN: begin
                // No fetching and no redirect; jumps resolving now are dropped.
                if (!dmem_wait) begin
                    if (id_stall) begin
                        // Hold IF/ID rather than flush it: it carries the waiting instruction.
                        ctl       = CTL_STALL;
                        stall_inc = 1'b1;
                    end else begin
                        ctl = CTL_NO_FETCH;
                    end
                    // Leave as the count reaches zero, giving DRAIN_CYCLES advancing cycles.
                    seq_cnt_nxt = seq_cnt - SEQ_W'(1);
                    if (seq_cnt == SEQ_W'(1)) begin
                        state_nxt = PCTL_HALTED;
                    end
                end
            end

            PCTL_HALTED: begin
                halted = 1'b1;
                if (!halt_req) begin
                    state_nxt = PCTL_RUN;
                end
            end

            default: begin
                state_nxt   = PCTL_INIT;
                seq_cnt_nxt = INIT_LOAD;
            end
        endcase
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid.en;
    assign ifid_flush  = ctl.ifid.flush;
    assign idex_en     = ctl.idex.en;
    assign idex_bubble = ctl.idex.flush;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;

    perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .clear   (state == PCTL_INIT),
        .cnt     (stall_cnt)
    );

    perf_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .clear   (state == PCTL_INIT),
        .cnt     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl. Control outputs are packed as
// {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted}.
module tb_pipe_ctl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_stall, ex_jmp_taken, imem_wait, dmem_wait, halt_req;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic [7:0]  ctl_vec;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [7:0] V_INIT   = 8'b0111_1110;
    localparam logic [7:0] V_FLOW   = 8'b1101_0110;
    localparam logic [7:0] V_STALL  = 8'b0001_1110;
    localparam logic [7:0] V_JMP    = 8'b1111_1110;
    localparam logic [7:0] V_FREEZE = 8'b0000_0000;
    localparam logic [7:0] V_NOFET  = 8'b0111_0110;
    localparam logic [7:0] V_HALTED = 8'b0000_0001;

    pipe_ctl #(.INIT_CYCLES(4), .CNT_WIDTH(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_stall     (id_stall),
        .ex_jmp_taken (ex_jmp_taken),
        .imem_wait    (imem_wait),
        .dmem_wait    (dmem_wait),
        .halt_req     (halt_req),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_bubble  (idex_bubble),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clock = ~clock;

    assign ctl_vec = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are changed and outputs sampled just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic stl, input logic jmp, input logic iw, input logic dw, input logic hr);
        id_stall     = stl;
        ex_jmp_taken = jmp;
        imem_wait    = iw;
        dmem_wait    = dw;
        halt_req     = hr;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        chk("rst_ctl", 32'(ctl_vec), 32'(V_INIT));
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        // Reset release: four INIT cycles, then RUN.
        tick();
        reset_n = 1'b1;
        #1;
        chk("init_c1", 32'(ctl_vec), 32'(V_INIT));
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("init_c%0d", i), 32'(ctl_vec), 32'(V_INIT));
        end
        tick();
        chk("run_first", 32'(ctl_vec), 32'(V_FLOW));

        // Two-cycle load-use stall.
        tick();
        drive(1, 0, 0, 0, 0);
        chk("stall_c1", 32'(ctl_vec), 32'(V_STALL));
        tick();
        chk("stall_c2", 32'(ctl_vec), 32'(V_STALL));
        chk("stall_cnt_1", stall_cnt, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("stall_cnt_2", stall_cnt, 2);
        chk("after_stall", 32'(ctl_vec), 32'(V_FLOW));

        // Jump and stall together: jump wins, stall not counted.
        tick();
        drive(1, 1, 0, 0, 0);
        chk("jmp_stall", 32'(ctl_vec), 32'(V_JMP));
        tick();
        drive(0, 0, 0, 0, 0);
        chk("jmp_flush_cnt", flush_cnt, 1);
        chk("jmp_stall_cnt", stall_cnt, 2);

        // Jump under dmem_wait is frozen, then applied once the wait clears.
        tick();
        drive(0, 1, 0, 1, 0);
        chk("dmem_jmp", 32'(ctl_vec), 32'(V_FREEZE));
        tick();
        chk("dmem_jmp_cnt", flush_cnt, 1);
        drive(0, 1, 0, 0, 0);
        chk("jmp_after_dmem", 32'(ctl_vec), 32'(V_JMP));
        tick();
        drive(0, 0, 0, 0, 0);
        chk("jmp_after_dmem_cnt", flush_cnt, 2);

        // imem_wait alone.
        drive(0, 0, 1, 0, 0);
        chk("imem_wait", 32'(ctl_vec), 32'(V_NOFET));
        tick();
        drive(0, 0, 0, 0, 0);

        // Halt: one RUN cycle, three DRAIN cycles plus one frozen, then HALTED.
        drive(0, 0, 0, 0, 1);
        chk("halt_run", 32'(ctl_vec), 32'(V_FLOW));
        tick();
        drive(0, 1, 0, 0, 1);
        chk("drain_c1_jmp_ignored", 32'(ctl_vec), 32'(V_NOFET));
        tick();
        chk("drain_no_flush_cnt", flush_cnt, 2);
        drive(0, 0, 0, 1, 1);
        chk("drain_frozen", 32'(ctl_vec), 32'(V_FREEZE));
        tick();
        drive(0, 0, 0, 0, 1);
        chk("drain_c2", 32'(ctl_vec), 32'(V_NOFET));
        tick();
        chk("drain_c3", 32'(ctl_vec), 32'(V_NOFET));
        tick();
        chk("halted_1", 32'(ctl_vec), 32'(V_HALTED));
        tick();
        chk("halted_2", 32'(ctl_vec), 32'(V_HALTED));
        drive(0, 0, 0, 0, 0);
        chk("halted_release", 32'(ctl_vec), 32'(V_HALTED));
        tick();
        chk("resume", 32'(ctl_vec), 32'(V_FLOW));

        // Build stall_cnt up to 7, enter DRAIN, then reset mid-cycle.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        drive(0, 0, 0, 0, 1);
        chk("stall_cnt_7", stall_cnt, 7);
        tick();
        chk("drain_before_rst", 32'(ctl_vec), 32'(V_NOFET));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_in_drain_ctl", 32'(ctl_vec), 32'(V_INIT));
        chk("rst_in_drain_stall", stall_cnt, 0);
        chk("rst_in_drain_flush", flush_cnt, 0);
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
